// File: rtl/sqrt_result_checker.sv
// sqrt_result_checker: squares a candidate root with a shift-add multiplier and reports the residual against R.
// Optional error statistics (err_max, sample_cnt) are built when SQR_ERR_STATS_EN is defined.
module sqrt_result_checker #(
    parameter int RW = 16,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] in_r,
    input  logic [QW-1:0] in_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_sq,
    output logic [RW:0]   out_res,
    output logic [RW:0]   out_abs_err,
    output logic          out_over
`ifdef SQR_ERR_STATS_EN
    ,
    output logic [RW:0]   err_max,
    output logic [15:0]   sample_cnt
`endif
);
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [RW-1:0] r_q, r_d;
    logic [RW-1:0] mcand_q, mcand_d;
    logic [QW-1:0] mplier_q, mplier_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_sq_q, out_sq_d;
    logic [RW:0]   out_res_q, out_res_d;
    logic [RW:0]   out_abs_q, out_abs_d;
    logic          out_over_q, out_over_d;
    logic [RW-1:0] acc_sum;
    logic [RW:0]   res_w;
`ifdef SQR_ERR_STATS_EN
    logic [RW:0]   err_max_q, err_max_d;
    logic [15:0]   sample_cnt_q, sample_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sq_d    = out_sq_q;
        out_res_d   = out_res_q;
        out_abs_d   = out_abs_q;
        out_over_d  = out_over_q;
`ifdef SQR_ERR_STATS_EN
        err_max_d    = err_max_q;
        sample_cnt_d = sample_cnt_q;
`endif
        // LSB-first partial product: the multiplicand shifts left as the multiplier shifts right
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        res_w   = {1'b0, r_q} - {1'b0, acc_sum};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d      = in_r;
                    mcand_d  = RW'(in_q);
                    mplier_d = in_q;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(QW - 1)) begin
                    out_sq_d    = acc_sum;
                    out_res_d   = res_w;
                    out_abs_d   = res_w[RW] ? -res_w : res_w;
                    out_over_d  = res_w[RW];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef SQR_ERR_STATS_EN
                    err_max_d    = (out_abs_q > err_max_q) ? out_abs_q : err_max_q;
                    sample_cnt_d = (sample_cnt_q == 16'hFFFF) ? sample_cnt_q : sample_cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            r_q         <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sq_q    <= '0;
            out_res_q   <= '0;
            out_abs_q   <= '0;
            out_over_q  <= 1'b0;
`ifdef SQR_ERR_STATS_EN
            err_max_q    <= '0;
            sample_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            r_q         <= r_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sq_q    <= out_sq_d;
            out_res_q   <= out_res_d;
            out_abs_q   <= out_abs_d;
            out_over_q  <= out_over_d;
`ifdef SQR_ERR_STATS_EN
            err_max_q    <= err_max_d;
            sample_cnt_q <= sample_cnt_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sq      = out_sq_q;
    assign out_res     = out_res_q;
    assign out_abs_err = out_abs_q;
    assign out_over    = out_over_q;
`ifdef SQR_ERR_STATS_EN
    assign err_max    = err_max_q;
    assign sample_cnt = sample_cnt_q;
`endif
endmodule
